alu_writeback_stage: RTL

//  Downstream of the ALU. Captures alu_out, the six ALU flags and per-op control into a 2-entry skid FIFO.

---
 rtl/alu_writeback_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: a 2-entry skid FIFO between the ALU and the register-file
// write port. The branch decision is made when an entry is captured. When an entry
// leaves the FIFO it updates the committed status flags, the sticky overflow bit and
// the saturating overflow counter.
//
// state | meaning
// ------+---------------------------------------------
// EMPTY | no entries held; out_valid=0, in_ready=1
// ONE   | one entry held; out_valid=1, in_ready=1
// FULL  | two entries held; out_valid=1, in_ready=0
module alu_writeback_stage #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    alu_out,
    input  logic                 zero,
    input  logic                 negative,
    input  logic                 overflow,
    input  logic                 equal_to,
    input  logic                 less_than,
    input  logic                 greater_than,
    input  logic [REG_AW-1:0]    dest_reg,
    input  logic                 wr_en,
    input  logic                 is_branch,
    input  logic [2:0]           cond,
    input  logic                 clr_ovf,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_result,
    output logic [REG_AW-1:0]    out_dest,
    output logic                 out_wr_en,
    output logic                 out_taken,
    output logic [5:0]           status_flags,
    output logic                 sticky_ovf,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    // Entry layout: {result, dest, wr_en, taken, flags{gt,lt,eq,ovf,neg,zero}}
    localparam int ENTRY_W = DATA_W + REG_AW + 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic   [1:0][ENTRY_W-1:0]     ent_q, ent_d;
    logic                          wr_ptr_q, wr_ptr_d;
    logic                          rd_ptr_q, rd_ptr_d;
    logic   [5:0]                  status_q, status_d;
    logic                          sticky_q, sticky_d;
    logic   [OVF_CNT_W-1:0]        cnt_q, cnt_d;

    logic                          push;
    logic                          pop;
    logic                          taken;
    logic   [5:0]                  in_flags;
    logic   [ENTRY_W-1:0]          in_entry;
    logic   [ENTRY_W-1:0]          head;

    // Handshake flags come from the registered state only, so there is no
    // combinational path from out_ready to in_ready.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Branch condition is evaluated on the incoming flags at capture time.
    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b000:  taken = 1'b0;
            3'b001:  taken = equal_to;
            3'b010:  taken = ~equal_to;
            3'b011:  taken = less_than;
            3'b100:  taken = greater_than;
            3'b101:  taken = less_than | equal_to;
            3'b110:  taken = greater_than | equal_to;
            default: taken = 1'b1;
        endcase
        taken    = taken & is_branch;
        in_flags = {greater_than, less_than, equal_to, overflow, negative, zero};
        in_entry = {alu_out, dest_reg, wr_en & ~is_branch, taken, in_flags};
    end

    // Occupancy FSM, storage write and pointer advance.
    always_comb begin
        state_d  = state_q;
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        if (push) begin
            ent_d[wr_ptr_q] = in_entry;
        end
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (pop && !push) state_d = EMPTY;
            end
            FULL:  if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Head entry drives the writeback port directly from storage.
    always_comb begin
        head       = ent_q[rd_ptr_q];
        out_result = head[ENTRY_W-1 -: DATA_W];
        out_dest   = head[REG_AW+7 -: REG_AW];
        out_wr_en  = head[7];
        out_taken  = head[6];
    end

    // Commit-side status. A pop carrying overflow wins over a same-cycle clear,
    // leaving the counter at one rather than zero.
    always_comb begin
        status_d = status_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr_ovf) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
        if (pop) begin
            status_d = head[5:0];
            if (head[2]) begin
                sticky_d = 1'b1;
                if (clr_ovf)            cnt_d = OVF_CNT_W'(1);
                else if (cnt_q != '1)   cnt_d = cnt_q + OVF_CNT_W'(1);
            end
        end
    end

    always_comb begin
        status_flags = status_q;
        sticky_ovf   = sticky_q;
        ovf_count    = cnt_q;
    end

    // State register; reset discards all entries and clears committed status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            ent_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            status_q <= '0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            status_q <= status_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
